vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 126 ++++++++++++
 tb/tb_vga_sync_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA timing generator.
// Produces active-low hsync/vsync, videoon, a pixel-rate tick and the
// current pixel coordinates. Every output is registered and is computed
// from the next-state counter values, so all outputs describe the same
// pixel as pixelx/pixely with no skew between them.
// Optional feature: define VGA_SYNC_FRAMETICK_EN to add a one-clk
// frametick pulse on the edge where the counters wrap to (0,0).
module vga_sync_gen #(
    parameter int HD  = 640,
    parameter int HF  = 16,
    parameter int HR  = 96,
    parameter int HB  = 48,
    parameter int VD  = 480,
    parameter int VF  = 10,
    parameter int VR  = 2,
    parameter int VB  = 33,
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       resetn,
    output logic       hsync,
    output logic       vsync,
    output logic       videoon,
    output logic       ptick,
`ifdef VGA_SYNC_FRAMETICK_EN
    output logic       frametick,
`endif
    output logic [9:0] pixelx,
    output logic [9:0] pixely
);

    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;

    localparam logic [9:0] H_LAST     = 10'(HT - 1);
    localparam logic [9:0] V_LAST     = 10'(VT - 1);
    localparam logic [9:0] H_DISP     = 10'(HD);
    localparam logic [9:0] V_DISP     = 10'(VD);
    localparam logic [9:0] HSYNC_FIRST = 10'(HD + HF);
    localparam logic [9:0] HSYNC_LAST  = 10'(HD + HF + HR - 1);
    localparam logic [9:0] VSYNC_FIRST = 10'(VD + VF);
    localparam logic [9:0] VSYNC_LAST  = 10'(VD + VF + VR - 1);
    localparam logic [3:0] DIV_LAST    = 4'(DIV - 1);

    // Counters are 10 bits wide and the divider is 4 bits wide, so
    // timings that do not fit are rejected at elaboration.
    if (HT > 1024 || VT > 1024 || DIV < 1 || DIV > 16 ||
        HD < 1 || HR < 1 || VD < 1 || VR < 1) begin : g_bad_params
        $error("vga_sync_gen: illegal timing parameters");
    end

    logic [3:0] div_cnt;
    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       frame_wrap;

    // Clock divider: ptick is high for the clk cycle after the divider
    // reaches its last count, giving one pulse per pixel period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= 4'd0;
            ptick   <= 1'b0;
        end else begin
            ptick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= 4'd0;
            end else begin
                div_cnt <= div_cnt + 4'd1;
            end
        end
    end

    // Next-state coordinates: advance one pixel per ptick, carrying into
    // the row counter at end of line and wrapping both at end of frame.
    always_comb begin
        x_next     = pixelx;
        y_next     = pixely;
        frame_wrap = 1'b0;
        if (ptick) begin
            if (pixelx == H_LAST) begin
                x_next = 10'd0;
                if (pixely == V_LAST) begin
                    y_next     = 10'd0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = pixely + 10'd1;
                end
            end else begin
                x_next = pixelx + 10'd1;
            end
        end
    end

    // Register coordinates and derive sync/blanking from the same
    // next-state values so everything changes on one edge together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixelx  <= 10'd0;
            pixely  <= 10'd0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            videoon <= 1'b0;
        end else begin
            pixelx  <= x_next;
            pixely  <= y_next;
            hsync   <= !((x_next >= HSYNC_FIRST) && (x_next <= HSYNC_LAST));
            vsync   <= !((y_next >= VSYNC_FIRST) && (y_next <= VSYNC_LAST));
            videoon <= (x_next < H_DISP) && (y_next < V_DISP);
        end
    end

`ifdef VGA_SYNC_FRAMETICK_EN
    // Frame tick: one-clk pulse on the edge that returns to (0,0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frametick <= 1'b0;
        end else begin
            frametick <= frame_wrap;
        end
    end
`else
    logic frame_wrap_unused;
    assign frame_wrap_unused = frame_wrap;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
// Two instances share one clock: "big" uses default 640x480 timing with
// DIV=2, "small" uses a tiny 16x8 timing with DIV=1 so whole frames fit.
// Expected values are hand-derived from the timing rules: after the n-th
// rising edge following reset release, big shows pixel floor((n-1)/2)
// and small shows linear position n-1.
module tb_vga_sync_gen;

    logic       clk = 1'b0;
    logic       big_resetn = 1'b0;
    logic       small_resetn = 1'b0;

    logic       big_hsync, big_vsync, big_videoon, big_ptick;
    logic [9:0] big_x, big_y;
    logic       small_hsync, small_vsync, small_videoon, small_ptick;
    logic [9:0] small_x, small_y;
`ifdef VGA_SYNC_FRAMETICK_EN
    logic       big_frametick, small_frametick;
`endif

    int compare_count  = 0;
    int mismatch_count = 0;
    int big_n   = 0;
    int small_n = 0;

    vga_sync_gen dut_big (
        .clk       (clk),
        .resetn    (big_resetn),
        .hsync     (big_hsync),
        .vsync     (big_vsync),
        .videoon   (big_videoon),
        .ptick     (big_ptick),
`ifdef VGA_SYNC_FRAMETICK_EN
        .frametick (big_frametick),
`endif
        .pixelx    (big_x),
        .pixely    (big_y)
    );

    vga_sync_gen #(
        .HD(8), .HF(2), .HR(2), .HB(4),
        .VD(4), .VF(1), .VR(1), .VB(2),
        .DIV(1)
    ) dut_small (
        .clk       (clk),
        .resetn    (small_resetn),
        .hsync     (small_hsync),
        .vsync     (small_vsync),
        .videoon   (small_videoon),
        .ptick     (small_ptick),
`ifdef VGA_SYNC_FRAMETICK_EN
        .frametick (small_frametick),
`endif
        .pixelx    (small_x),
        .pixely    (small_y)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clk and land on the following falling edge for sampling.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            big_n++;
            small_n++;
        end
    endtask

    task automatic checkBigAt(input int n, input int x, input int y,
                              input logic von, input logic hs);
        if (big_n < n) applyStimulus(n - big_n);
        checkOutput($sformatf("big x @%0d", n), 32'(big_x), 32'(x));
        checkOutput($sformatf("big y @%0d", n), 32'(big_y), 32'(y));
        checkOutput($sformatf("big videoon @%0d", n), 32'(big_videoon), 32'(von));
        checkOutput($sformatf("big hsync @%0d", n), 32'(big_hsync), 32'(hs));
        checkOutput($sformatf("big vsync @%0d", n), 32'(big_vsync), 32'd1);
    endtask

    task automatic checkBigReset(input string tag);
        checkOutput({tag, " x"}, 32'(big_x), 32'd0);
        checkOutput({tag, " y"}, 32'(big_y), 32'd0);
        checkOutput({tag, " hsync"}, 32'(big_hsync), 32'd1);
        checkOutput({tag, " vsync"}, 32'(big_vsync), 32'd1);
        checkOutput({tag, " videoon"}, 32'(big_videoon), 32'd0);
        checkOutput({tag, " ptick"}, 32'(big_ptick), 32'd0);
    endtask

    initial begin
        int ex, ey;

        // Reset held for 10 clks on both instances
        applyStimulus(10);
        checkBigReset("rst big");
        checkOutput("rst small x", 32'(small_x), 32'd0);
        checkOutput("rst small y", 32'(small_y), 32'd0);
        checkOutput("rst small hsync", 32'(small_hsync), 32'd1);
        checkOutput("rst small vsync", 32'(small_vsync), 32'd1);
        checkOutput("rst small videoon", 32'(small_videoon), 32'd0);
        checkOutput("rst small ptick", 32'(small_ptick), 32'd0);

        // Release big instance; first edge raises videoon
        big_resetn = 1'b1;
        big_n = 0;
        for (int n = 1; n <= 20; n++) begin
            applyStimulus(1);
            checkOutput($sformatf("div2 x @%0d", n), 32'(big_x), 32'((n - 1) / 2));
            checkOutput($sformatf("div2 ptick @%0d", n), 32'(big_ptick), 32'(n % 2 == 0));
            if (n == 1) checkOutput("release videoon", 32'(big_videoon), 32'd1);
        end

        // One full line at default timing
        checkBigAt(1279, 639, 0, 1'b1, 1'b1);
        checkBigAt(1281, 640, 0, 1'b0, 1'b1);
        checkBigAt(1311, 655, 0, 1'b0, 1'b1);
        checkBigAt(1313, 656, 0, 1'b0, 1'b0);
        checkBigAt(1504, 751, 0, 1'b0, 1'b0);
        checkBigAt(1505, 752, 0, 1'b0, 1'b1);
        checkBigAt(1600, 799, 0, 1'b0, 1'b1);
        checkBigAt(1601, 0, 1, 1'b1, 1'b1);
        checkBigAt(1603, 1, 1, 1'b1, 1'b1);
        checkBigAt(2201, 300, 1, 1'b1, 1'b1);

        // Asynchronous reset mid-line, between clock edges
        #2;
        big_resetn = 1'b0;
        #1;
        checkBigReset("async rst");
        @(negedge clk);
        applyStimulus(3);
        checkBigReset("rst hold");
        big_resetn = 1'b1;
        big_n = 0;
        applyStimulus(1);
        checkOutput("restart x @1", 32'(big_x), 32'd0);
        checkOutput("restart y @1", 32'(big_y), 32'd0);
        checkOutput("restart videoon @1", 32'(big_videoon), 32'd1);
        applyStimulus(2);
        checkOutput("restart x @3", 32'(big_x), 32'd1);
        checkOutput("restart y @3", 32'(big_y), 32'd0);

        // Small timing, DIV=1: more than one full 128-clk frame
        small_resetn = 1'b1;
        small_n = 0;
        for (int n = 1; n <= 140; n++) begin
            applyStimulus(1);
            ex = (n - 1) % 16;
            ey = ((n - 1) / 16) % 8;
            checkOutput($sformatf("small x @%0d", n), 32'(small_x), 32'(ex));
            checkOutput($sformatf("small y @%0d", n), 32'(small_y), 32'(ey));
            checkOutput($sformatf("small ptick @%0d", n), 32'(small_ptick), 32'd1);
            checkOutput($sformatf("small videoon @%0d", n), 32'(small_videoon),
                        32'(ex < 8 && ey < 4));
            checkOutput($sformatf("small hsync @%0d", n), 32'(small_hsync),
                        32'(!(ex >= 10 && ex <= 11)));
            checkOutput($sformatf("small vsync @%0d", n), 32'(small_vsync), 32'(ey != 5));
`ifdef VGA_SYNC_FRAMETICK_EN
            checkOutput($sformatf("small frametick @%0d", n), 32'(small_frametick),
                        32'(n == 129));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
